// File: rtl/seg7_to_three_decoder.sv
// Decodes a debounced 7-segment pattern back to its 3-bit code.
// Accepted codes go out over valid/ready; patterns not in the table raise a pulse and bump a counter.
module seg7_to_three_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg_in,
    input  logic                 code_ready,
    output logic [2:0]           code_out,
    output logic                 code_valid,
    output logic                 bad_pattern,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned RUN_W  = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [SEG_W-1:0]       s_q, s_d;
    logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
    logic [SEG_W-1:0]       last_acc_q, last_acc_d;
    logic                   have_last_q, have_last_d;
    logic [CODE_W-1:0]      code_out_q, code_out_d;
    logic                   code_valid_q, code_valid_d;
    logic                   bad_pattern_q, bad_pattern_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic                   dec_ok;
    logic [CODE_W-1:0]      dec_code;
    logic                   stable;

    // Exact-match lookup of the sampled pattern
    always_comb begin
        dec_ok   = 1'b1;
        dec_code = '0;
        case (s_q)
            7'b1100000: dec_code = 3'd0;
            7'b1000010: dec_code = 3'd1;
            7'b1100010: dec_code = 3'd2;
            7'b1100011: dec_code = 3'd3;
            7'b1100111: dec_code = 3'd4;
            7'b1101111: dec_code = 3'd5;
            7'b1110111: dec_code = 3'd6;
            7'b0111111: dec_code = 3'd7;
            default:    dec_ok   = 1'b0;
        endcase
    end

    assign stable = (run_cnt_q == RUN_MAX);

    always_comb begin
        s_d           = seg_in;
        run_cnt_d     = RUN_W'(1);
        state_d       = state_q;
        last_acc_d    = last_acc_q;
        have_last_d   = have_last_q;
        code_out_d    = code_out_q;
        code_valid_d  = code_valid_q;
        bad_pattern_d = 1'b0;
        err_count_d   = err_count_q;

        if (run_cnt_q != '0 && seg_in == s_q) begin
            run_cnt_d = (run_cnt_q >= RUN_MAX) ? RUN_MAX : run_cnt_q + RUN_W'(1);
        end

        // Candidate is always the registered sample, so a same-edge input change is harmless
        if (state_q == ST_WAIT) begin
            if (stable && (!have_last_q || s_q != last_acc_q)) begin
                last_acc_d  = s_q;
                have_last_d = 1'b1;
                if (dec_ok) begin
                    code_out_d   = dec_code;
                    code_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    bad_pattern_d = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_CNT_W'(1);
                    end
                end
            end
        end else begin
            if (code_ready) begin
                code_valid_d = 1'b0;
                state_d      = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_WAIT;
            s_q           <= '0;
            run_cnt_q     <= '0;
            last_acc_q    <= '0;
            have_last_q   <= 1'b0;
            code_out_q    <= '0;
            code_valid_q  <= 1'b0;
            bad_pattern_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            run_cnt_q     <= run_cnt_d;
            last_acc_q    <= last_acc_d;
            have_last_q   <= have_last_d;
            code_out_q    <= code_out_d;
            code_valid_q  <= code_valid_d;
            bad_pattern_q <= bad_pattern_d;
            err_count_q   <= err_count_d;
        end
    end

    assign code_out    = code_out_q;
    assign code_valid  = code_valid_q;
    assign bad_pattern = bad_pattern_q;
    assign err_count   = err_count_q;

endmodule
